spi_slave_core: RTL and testbench

- Byte-oriented SPI responder for the SPI subsystem, mode 0 (CPOL=0, CPHA=0), MSB first.
- Runs on the system clock and oversamples the master's sclk, ss and mosi through synchronisers.
- Gives local logic a valid/ready TX byte interface and a valid/ready RX byte interface, so firmware-side logic can answer spi_master transfers with real data.
- Supports multi-byte frames: ss held low across several bytes.

---
 rtl/spi_slave_core.sv | 120 ++++++++++++
 tb/tb_spi_slave_core.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// spi_slave_core: mode-0 SPI slave on the system clock with synchronised inputs
// and valid/ready TX/RX byte interfaces; multi-byte frames while ss stays low.
module spi_slave_core #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              busy
);
  localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic [SYNC_STAGES:0] r_flush;
  logic r_sclk_p, r_ss_p, r_armed;
  logic w_sclk_s, w_ss_s, w_mosi_s, w_active, w_rise, w_fall, w_ss_fall, w_ss_rise;
  logic w_load, w_tx_wr, w_rx_take;
  logic [CW-1:0] r_bit_cnt;
  logic r_reload, r_rx_done, r_tx_full;
  logic [DATA_W-1:0] r_tx_hold, r_tx_shift, r_rx_shift;

  assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_s    = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_active  = r_state == ACTIVE;
  assign w_rise    = w_active & w_sclk_s & ~r_sclk_p;
  assign w_fall    = w_active & ~w_sclk_s & r_sclk_p;
  // A frame already running when reset ends must not start on the chain flush edge
  assign w_ss_fall = r_armed & r_ss_p & ~w_ss_s;
  assign w_ss_rise = ~r_ss_p & w_ss_s;
  assign w_load    = (~w_active & w_ss_fall) | (w_fall & r_reload);
  assign w_tx_wr   = tx_valid & ~r_tx_full;
  assign w_rx_take = r_rx_done & (~rx_valid | rx_ready);
  assign tx_ready  = ~r_tx_full;
  assign miso_oe   = ~w_ss_s;
  assign miso      = ~w_ss_s & r_tx_shift[DATA_W-1];
  assign busy      = w_active;

  always_comb w_state_nxt = w_active ? (w_ss_rise ? IDLE : ACTIVE) : (w_ss_fall ? ACTIVE : IDLE);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_flush     <= '0;
      r_sclk_p    <= 1'b0;
      r_ss_p      <= 1'b1;
      r_armed     <= 1'b0;
      r_state     <= IDLE;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_flush     <= {r_flush[SYNC_STAGES-1:0], 1'b1};
      r_sclk_p    <= w_sclk_s;
      r_ss_p      <= w_ss_s;
      r_armed     <= r_armed | (r_flush[SYNC_STAGES] & w_ss_s);
      r_state     <= w_state_nxt;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_bit_cnt  <= '0;
      r_reload   <= 1'b0;
      r_rx_done  <= 1'b0;
      r_rx_shift <= '0;
    end else begin
      r_rx_done <= w_rise & ~w_ss_rise & (r_bit_cnt == LAST);
      if (w_ss_rise) begin
        r_bit_cnt <= '0;
        r_reload  <= 1'b0;
      end else if (w_rise) begin
        r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_mosi_s};
        r_bit_cnt  <= r_bit_cnt == LAST ? '0 : r_bit_cnt + 1'b1;
        r_reload   <= r_bit_cnt == LAST;
      end else if (w_fall)
        r_reload <= 1'b0;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_tx_full   <= 1'b0;
      r_tx_hold   <= '0;
      r_tx_shift  <= '0;
      tx_underrun <= 1'b0;
    end else begin
      r_tx_full   <= w_tx_wr | (r_tx_full & ~w_load);
      if (w_tx_wr) r_tx_hold <= tx_data;
      tx_underrun <= w_load & ~r_tx_full;
      r_tx_shift  <= w_load ? (r_tx_full ? r_tx_hold : '0) : w_fall ? r_tx_shift << 1 : r_tx_shift;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (w_rx_take) rx_data <= r_rx_shift;
      rx_valid <= w_rx_take | (rx_valid & ~rx_ready);
      overrun  <= (r_rx_done & rx_valid & ~rx_ready) | (overrun & ~ovr_clr);
    end
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: randomized mode-0 SPI master driving spi_slave_core, checked
// against per-frame byte/queue expectations.
module tb_spi_slave_core;
  logic clk = 0, rst = 1, sclk = 0, ss = 0, mosi = 0;
  logic miso, miso_oe, tx_ready, tx_underrun, rx_valid, overrun, busy;
  logic tx_valid = 0, rx_ready = 1, ovr_clr = 0;
  logic [7:0] tx_data = 0, rx_data;
  int n_chk = 0, n_pass = 0, un_cnt = 0, rx_rd = 0, un0;
  logic [7:0] rx_got[$];
  logic [7:0] f_mosi[4], f_tx[5], f_miso[4];
  bit f_prov[5];

  always #5 clk = ~clk;

  spi_slave_core dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_underrun(tx_underrun),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .ovr_clr(ovr_clr), .busy(busy)
  );

  always @(negedge clk) begin
    #2;
    if (rx_valid && rx_ready) rx_got.push_back(rx_data);
    if (tx_underrun) un_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] v);
    chk("tx_ready_before_write", 32'(tx_ready), 1);
    tx_data = v;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
  endtask

  task automatic send_frame(input int n, input int abort_bits);
    int sent = 0;
    if (f_prov[0]) write_tx(f_tx[0]);
    ss = 0;
    clks(4);
    chk("busy_in_frame", 32'(busy), 1);
    chk("miso_oe_in_frame", 32'(miso_oe), 1);
    chk("tx_ready_after_load", 32'(tx_ready), 1);
    for (int b = 0; b < n; b++)
      for (int i = 7; i >= 0; i--)
        if (abort_bits == 0 || sent < abort_bits) begin
          mosi = f_mosi[b][i];
          if (i == 4 && f_prov[b+1]) begin
            write_tx(f_tx[b+1]);
            clks(4);
          end else clks(5);
          f_miso[b][i] = miso;
          sclk = 1;
          clks(5);
          sclk = 0;
          sent++;
        end
    clks(5);
    ss = 1;
    clks(6);
    chk("busy_after_frame", 32'(busy), 0);
    chk("miso_oe_after_frame", 32'(miso_oe), 0);
    chk("miso_after_frame", 32'(miso), 0);
  endtask

  // Every load point (ss fall, then each byte end) takes the held byte or zeros on underrun.
  task automatic check_frame(input int n, input int u0, input int exp_rx);
    int exp_un = 0;
    for (int k = 0; k <= n; k++) if (!f_prov[k]) exp_un++;
    chk("underrun_pulses", un_cnt - u0, exp_un);
    chk("rx_count", rx_got.size() - rx_rd, exp_rx);
    for (int b = 0; b < n; b++) chk("miso_byte", 32'(f_miso[b]), f_prov[b] ? 32'(f_tx[b]) : 0);
    for (int b = 0; b < exp_rx; b++)
      if (rx_rd + b < rx_got.size()) chk("rx_byte", 32'(rx_got[rx_rd+b]), 32'(f_mosi[b]));
    rx_rd = rx_got.size();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 6; i++) begin
      sclk = ~sclk;
      clks(3);
    end
    chk("rst_miso", 32'(miso), 0);
    chk("rst_miso_oe", 32'(miso_oe), 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_tx_underrun", 32'(tx_underrun), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom);
      clks(5);
      sclk = 1;
      clks(5);
      sclk = 0;
    end
    chk("ignored_frame_busy", 32'(busy), 0);
    chk("ignored_frame_rx", rx_got.size(), 0);
    chk("ignored_frame_underrun", un_cnt, 0);
    ss = 1;
    clks(6);

    f_prov = '{1, 0, 0, 0, 0};
    f_tx[0] = 8'hA5;
    f_mosi[0] = 8'h3C;
    un0 = un_cnt;
    send_frame(1, 0);
    check_frame(1, un0, 1);
    chk("single_rx_data", 32'(rx_data), 32'h3C);

    f_prov = '{1, 1, 0, 0, 0};
    f_tx[0] = 8'h81;
    f_tx[1] = 8'h7E;
    f_mosi[0] = 8'h55;
    f_mosi[1] = 8'hAA;
    un0 = un_cnt;
    send_frame(2, 0);
    check_frame(2, un0, 2);

    f_prov = '{0, 1, 0, 0, 0};
    f_tx[1] = 8'($urandom);
    f_mosi[0] = 8'($urandom);
    un0 = un_cnt;
    send_frame(1, 0);
    check_frame(1, un0, 1);

    rx_ready = 0;
    f_prov = '{1, 1, 1, 0, 0};
    f_tx[0] = 8'($urandom);
    f_tx[1] = 8'($urandom);
    f_tx[2] = 8'($urandom);
    f_mosi[0] = 8'h11;
    f_mosi[1] = 8'h22;
    un0 = un_cnt;
    send_frame(2, 0);
    chk("ovr_rx_data", 32'(rx_data), 32'h11);
    chk("ovr_rx_valid", 32'(rx_valid), 1);
    chk("ovr_flag", 32'(overrun), 1);
    ovr_clr = 1;
    clks(1);
    ovr_clr = 0;
    clks(1);
    chk("ovr_cleared", 32'(overrun), 0);
    rx_ready = 1;
    clks(3);
    check_frame(2, un0, 1);

    f_prov = '{1, 0, 0, 0, 0};
    f_tx[0] = 8'($urandom);
    f_mosi[0] = 8'($urandom);
    un0 = un_cnt;
    send_frame(1, 5);
    check_frame(0, un0, 0);
    chk("abort_rx_valid", 32'(rx_valid), 0);

    f_prov = '{1, 1, 0, 0, 0};
    f_tx[0] = 8'($urandom);
    f_tx[1] = 8'($urandom);
    f_mosi[0] = 8'hF0;
    un0 = un_cnt;
    send_frame(1, 0);
    check_frame(1, un0, 1);

    for (int r = 0; r < 6; r++) begin
      int n = int'($urandom_range(1, 3));
      for (int k = 0; k < 5; k++) begin
        f_prov[k] = k <= n ? 1'($urandom) : 1'b0;
        f_tx[k] = 8'($urandom);
      end
      for (int b = 0; b < 4; b++) f_mosi[b] = 8'($urandom);
      un0 = un_cnt;
      send_frame(n, 0);
      check_frame(n, un0, n);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
